// File: rtl/motion_sequencer_if.sv
// rtl/motion_sequencer_if.sv - command handshake and motor drive bundle for the motion sequencer
interface motion_sequencer_if #(
  parameter int DUTY_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [DUTY_WIDTH-1:0] cmd_duty;
  logic [15:0]           cmd_ticks;
  logic                  abort;
  logic [1:0]            left_motor;
  logic [1:0]            right_motor;
  logic [DUTY_WIDTH-1:0] left_duty;
  logic [DUTY_WIDTH-1:0] right_duty;
  logic [1:0]            motor_enable;
  logic                  busy;
  logic                  done;

  modport master (
    output cmd_valid, cmd_op, cmd_duty, cmd_ticks, abort,
    input  cmd_ready, left_motor, right_motor, left_duty, right_duty,
    input  motor_enable, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_duty, cmd_ticks, abort,
    output cmd_ready, left_motor, right_motor, left_duty, right_duty,
    output motor_enable, busy, done
  );
endinterface

// File: rtl/motion_sequencer.sv
// rtl/motion_sequencer.sv - sequences H-bridge pins, dead-time, duty ramp and run time per command
module motion_sequencer #(
  parameter int DUTY_WIDTH = 16,
  parameter int TICK_DIV   = 50000,
  parameter int RAMP_STEP  = 256,
  parameter int DEAD_TICKS = 4
) (
  input logic             clk,
  input logic             rst,
  motion_sequencer_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]         TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DUTY_WIDTH-1:0] STEP      = DUTY_WIDTH'(RAMP_STEP);
  localparam logic [15:0]           DEAD_LAST = 16'(DEAD_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_RAMP, S_RUN} state_t;

  state_t                r_state, w_state_nx;
  logic [PW-1:0]         r_presc;
  logic [1:0]            r_left, r_right, w_left_nx, w_right_nx;
  logic [1:0]            r_dir_l, r_dir_r, w_dir_l_nx, w_dir_r_nx;
  logic [DUTY_WIDTH-1:0] r_duty, r_target, w_duty_nx, w_target_nx;
  logic [15:0]           r_ticks, r_cnt, w_ticks_nx, w_cnt_nx;
  logic                  r_done, w_done_nx;
  logic                  w_tick, w_accept, w_need_dead;
  logic [1:0]            w_op_l, w_op_r;
  logic                  w_is_motion, w_is_brake;

  assign w_tick   = (r_presc == TICK_LAST);
  assign w_accept = bus.cmd_valid && bus.cmd_ready;

  assign bus.cmd_ready    = (r_state == S_IDLE) && !bus.abort;
  assign bus.busy         = !bus.cmd_ready;
  assign bus.left_motor   = r_left;
  assign bus.right_motor  = r_right;
  assign bus.left_duty    = r_duty;
  assign bus.right_duty   = r_duty;
  assign bus.done         = r_done;
  assign bus.motor_enable = {(r_duty != '0) || (r_right == 2'b11),
                             (r_duty != '0) || (r_left == 2'b11)};

  // free-running timing prescaler; tick marks its last count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_presc <= '0;
    else      r_presc <= w_tick ? '0 : r_presc + 1'b1;
  end

  // decode the requested per-motor pin pattern from the op code
  always_comb begin
    w_op_l      = 2'b00;
    w_op_r      = 2'b00;
    w_is_motion = 1'b1;
    w_is_brake  = 1'b0;
    case (bus.cmd_op)
      3'd1:    begin w_op_l = 2'b10; w_op_r = 2'b10; end
      3'd2:    begin w_op_l = 2'b01; w_op_r = 2'b01; end
      3'd3:    begin w_op_l = 2'b01; w_op_r = 2'b10; end
      3'd4:    begin w_op_l = 2'b10; w_op_r = 2'b01; end
      3'd5:    begin w_is_motion = 1'b0; w_is_brake = 1'b1; end
      default: w_is_motion = 1'b0;
    endcase
    w_need_dead = ((w_op_l != r_left)  && (r_left  != 2'b00)) ||
                  ((w_op_r != r_right) && (r_right != 2'b00));
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  // next-state and next datapath values; abort overrides everything
  always_comb begin
    w_state_nx  = r_state;
    w_left_nx   = r_left;
    w_right_nx  = r_right;
    w_dir_l_nx  = r_dir_l;
    w_dir_r_nx  = r_dir_r;
    w_duty_nx   = r_duty;
    w_target_nx = r_target;
    w_ticks_nx  = r_ticks;
    w_cnt_nx    = r_cnt;
    w_done_nx   = 1'b0;
    if (bus.abort) begin
      w_state_nx = S_IDLE;
      w_left_nx  = 2'b00;
      w_right_nx = 2'b00;
      w_duty_nx  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_target_nx = bus.cmd_duty;
            w_ticks_nx  = bus.cmd_ticks;
            w_cnt_nx    = '0;
            if (w_is_brake) begin
              w_left_nx   = 2'b11;
              w_right_nx  = 2'b11;
              w_duty_nx   = '1;
              w_target_nx = '1;
              w_state_nx  = S_RUN;
            end else if (w_is_motion) begin
              w_dir_l_nx = w_op_l;
              w_dir_r_nx = w_op_r;
              if (w_need_dead) begin
                w_left_nx  = 2'b00;
                w_right_nx = 2'b00;
                w_duty_nx  = '0;
                w_state_nx = S_DEAD;
              end else begin
                w_left_nx  = w_op_l;
                w_right_nx = w_op_r;
                w_state_nx = S_RAMP;
              end
            end else begin
              w_left_nx  = 2'b00;
              w_right_nx = 2'b00;
              w_duty_nx  = '0;
              w_done_nx  = 1'b1;
            end
          end
        end
        S_DEAD: begin
          if (w_tick) begin
            if (r_cnt == DEAD_LAST) begin
              w_left_nx  = r_dir_l;
              w_right_nx = r_dir_r;
              w_cnt_nx   = '0;
              w_state_nx = S_RAMP;
            end else begin
              w_cnt_nx = r_cnt + 16'd1;
            end
          end
        end
        S_RAMP: begin
          if (r_duty == r_target) begin
            w_cnt_nx   = '0;
            w_state_nx = S_RUN;
          end else if (w_tick) begin
            if (r_duty < r_target)
              w_duty_nx = (r_target - r_duty <= STEP) ? r_target : r_duty + STEP;
            else
              w_duty_nx = (r_duty - r_target <= STEP) ? r_target : r_duty - STEP;
          end
        end
        default: begin
          if (r_ticks == 16'd0) begin
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end else if (w_tick) begin
            if (r_cnt + 16'd1 == r_ticks) begin
              w_done_nx  = 1'b1;
              w_state_nx = S_IDLE;
            end else begin
              w_cnt_nx = r_cnt + 16'd1;
            end
          end
        end
      endcase
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_left   <= 2'b00;
      r_right  <= 2'b00;
      r_dir_l  <= 2'b00;
      r_dir_r  <= 2'b00;
      r_duty   <= '0;
      r_target <= '0;
      r_ticks  <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_left   <= w_left_nx;
      r_right  <= w_right_nx;
      r_dir_l  <= w_dir_l_nx;
      r_dir_r  <= w_dir_r_nx;
      r_duty   <= w_duty_nx;
      r_target <= w_target_nx;
      r_ticks  <= w_ticks_nx;
      r_cnt    <= w_cnt_nx;
      r_done   <= w_done_nx;
    end
  end
endmodule

// File: tb/tb_motion_sequencer.sv
// tb/tb_motion_sequencer.sv - scoreboard bench for motion_sequencer
module tb_motion_sequencer;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  motion_sequencer_if #(.DUTY_WIDTH(DW)) bus();

  motion_sequencer #(
    .DUTY_WIDTH(DW), .TICK_DIV(1), .RAMP_STEP(256), .DEAD_TICKS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  l;
    logic [1:0]  r;
    logic [15:0] duty;
    logic        done;
    logic        ready;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  m_l, m_r;
  logic [15:0] m_duty;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs_vec();
    return {23'd0, bus.left_motor, bus.right_motor, bus.left_duty, bus.right_duty,
            bus.motor_enable, bus.done, bus.cmd_ready, bus.busy};
  endfunction

  function automatic logic [63:0] exp_vec(input exp_t e);
    logic [1:0] en;
    en = {(e.duty != 0) || (e.r == 2'b11), (e.duty != 0) || (e.l == 2'b11)};
    return {23'd0, e.l, e.r, e.duty, e.duty, en, e.done, e.ready, !e.ready};
  endfunction

  task automatic push(input logic [1:0] l, input logic [1:0] r, input logic [15:0] d,
                      input logic dn, input logic rdy);
    exp_t e;
    e.l = l; e.r = r; e.duty = d; e.done = dn; e.ready = rdy;
    sb_q.push_back(e);
  endtask

  task automatic step_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    check(tag, obs_vec(), exp_vec(e));
  endtask

  // expected per-cycle trace for one accepted command, starting from model state
  task automatic gen_cmd(input logic [2:0] op, input logic [15:0] duty, input logic [15:0] ticks);
    logic [1:0] nl, nr;
    int run_n;
    run_n = (ticks == 0) ? 1 : int'(ticks);
    case (op)
      3'd1: begin nl = 2'b10; nr = 2'b10; end
      3'd2: begin nl = 2'b01; nr = 2'b01; end
      3'd3: begin nl = 2'b01; nr = 2'b10; end
      3'd4: begin nl = 2'b10; nr = 2'b01; end
      default: begin nl = 2'b00; nr = 2'b00; end
    endcase
    if (op == 3'd5) begin
      m_l = 2'b11; m_r = 2'b11; m_duty = 16'hFFFF;
      for (int i = 0; i < run_n; i++) push(m_l, m_r, m_duty, 1'b0, 1'b0);
      push(m_l, m_r, m_duty, 1'b1, 1'b1);
    end else if (op == 3'd0 || op > 3'd5) begin
      m_l = 2'b00; m_r = 2'b00; m_duty = 16'd0;
      push(m_l, m_r, m_duty, 1'b1, 1'b1);
    end else begin
      if (((nl != m_l) && (m_l != 2'b00)) || ((nr != m_r) && (m_r != 2'b00))) begin
        for (int i = 0; i < 4; i++) push(2'b00, 2'b00, 16'd0, 1'b0, 1'b0);
        m_duty = 16'd0;
      end
      m_l = nl; m_r = nr;
      push(m_l, m_r, m_duty, 1'b0, 1'b0);
      while (m_duty != duty) begin
        if (m_duty < duty) m_duty = (duty - m_duty <= 16'd256) ? duty : m_duty + 16'd256;
        else               m_duty = (m_duty - duty <= 16'd256) ? duty : m_duty - 16'd256;
        push(m_l, m_r, m_duty, 1'b0, 1'b0);
      end
      for (int i = 0; i < run_n; i++) push(m_l, m_r, m_duty, 1'b0, 1'b0);
      push(m_l, m_r, m_duty, 1'b1, 1'b1);
    end
    push(m_l, m_r, m_duty, 1'b0, 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() > 0) begin
      step_check($sformatf("%s_c%0d", name, n));
      n++;
      if (sb_q.size() > 0) @(negedge clk);
    end
  endtask

  // called at a negedge with the bench idle; leaves off at the negedge of the idle cycle
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [15:0] duty,
                         input logic [15:0] ticks);
    gen_cmd(op, duty, ticks);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_duty = duty; bus.cmd_ticks = ticks;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd2; bus.cmd_duty = 16'hA5A5; bus.cmd_ticks = 16'd9;
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_duty = 16'd0;
    bus.cmd_ticks = 16'd0; bus.abort = 1'b0;
    m_l = 2'b00; m_r = 2'b00; m_duty = 16'd0;

    repeat (3) @(negedge clk);
    push(2'b00, 2'b00, 16'd0, 1'b0, 1'b1);
    step_check("reset");
    rst = 1'b1;
    @(negedge clk);
    push(2'b00, 2'b00, 16'd0, 1'b0, 1'b1);
    step_check("idle_after_reset");

    run_cmd("fwd1024", 3'd1, 16'd1024, 16'd3);
    run_cmd("fwd1000", 3'd1, 16'd1000, 16'd1);
    run_cmd("rev512",  3'd2, 16'd512,  16'd2);
    run_cmd("fwd1024b", 3'd1, 16'd1024, 16'd0);
    run_cmd("fwd300",  3'd1, 16'd300,  16'd0);
    run_cmd("stop",    3'd0, 16'd777,  16'd5);

    // abort during the ramp of a left turn
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd3; bus.cmd_duty = 16'd4096; bus.cmd_ticks = 16'd5;
    push(2'b01, 2'b10, 16'd0, 1'b0, 1'b0);
    push(2'b01, 2'b10, 16'd256, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    step_check("turnl_c0");
    @(negedge clk);
    step_check("turnl_c1");
    bus.abort = 1'b1;
    #1;
    push(2'b01, 2'b10, 16'd256, 1'b0, 1'b0);
    step_check("abort_ready_low");
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1; bus.cmd_duty = 16'd512; bus.cmd_ticks = 16'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push(2'b00, 2'b00, 16'd0, 1'b0, 1'b0);
      step_check($sformatf("abort_hold_%0d", i));
    end
    bus.cmd_valid = 1'b0;
    bus.abort = 1'b0;
    #1;
    push(2'b00, 2'b00, 16'd0, 1'b0, 1'b1);
    step_check("abort_release");
    m_l = 2'b00; m_r = 2'b00; m_duty = 16'd0;
    @(negedge clk);

    run_cmd("brake", 3'd5, 16'd123, 16'd2);
    run_cmd("op7",   3'd7, 16'd999, 16'd4);

    // asynchronous reset while running
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1; bus.cmd_duty = 16'd256; bus.cmd_ticks = 16'd20;
    push(2'b10, 2'b10, 16'd0, 1'b0, 1'b0);
    push(2'b10, 2'b10, 16'd256, 1'b0, 1'b0);
    push(2'b10, 2'b10, 16'd256, 1'b0, 1'b0);
    push(2'b10, 2'b10, 16'd256, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    drain("run20");
    #2;
    rst = 1'b0;
    #1;
    push(2'b00, 2'b00, 16'd0, 1'b0, 1'b1);
    step_check("async_reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      push(2'b00, 2'b00, 16'd0, 1'b0, 1'b1);
      step_check($sformatf("post_reset_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/motion_sequencer.md
Name: motion_sequencer

Overview:
Command-level controller for the two motor drivers on the bot. Accepts one drive command at a time over a valid/ready handshake and sequences direction pins, dead-time, duty ramping and run duration. Its outputs feed the left and right PWM motor driver instances and the motor enable pins. Sits between the top-level behaviour logic and the motor drivers.

Parameters:
DUTY_WIDTH, 16, width of duty values; matches the motor driver COUNTER_WIDTH.
TICK_DIV, 50000, clk cycles per timing tick; must be at least 1.
RAMP_STEP, 256, duty change per tick during RAMP.
DEAD_TICKS, 4, coast ticks inserted on a direction change; must be at least 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  3  0 STOP, 1 FWD, 2 REV, 3 TURN_L, 4 TURN_R, 5 BRAKE, 6/7 treated as STOP
cmd_duty  in  DUTY_WIDTH  target duty (ignored for STOP/BRAKE)
cmd_ticks  in  16  run duration in ticks after the target is reached
abort  in  1  synchronous abort, level-sampled
left_motor  out  2  left H-bridge pins: 10 fwd, 01 rev, 00 coast, 11 brake
right_motor  out  2  right H-bridge pins, same encoding
left_duty  out  DUTY_WIDTH  duty to the left motor driver
right_duty  out  DUTY_WIDTH  duty to the right motor driver
motor_enable  out  2  {right,left} enable
busy  out  1  command in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - Both motor pin pairs = 00, both duties = 0, motor_enable = 00.
  - cmd_ready = 1, busy = 0, done = 0.
  - Prescaler, tick counter and stored direction = 0.
  - Reset mid-command discards the command. No done pulse.
- Tick:
  - The prescaler is free-running, counting 0..TICK_DIV-1.
  - tick = 1 for one cycle when the count = TICK_DIV-1.
  - With TICK_DIV = 1, tick is 1 every cycle.
- Per-motor direction by op:
  - FWD: 10/10. REV: 01/01.
  - TURN_L: left 01, right 10. TURN_R: left 10, right 01.
  - BRAKE: 11/11. STOP: 00/00.
- Duty is common to both sides: left_duty = right_duty = current duty.
- motor_enable[i] = 1 when the current duty != 0 or that motor's pins = 11.
- cmd_ready = 1 only in IDLE and only when abort = 0.
- Handshake: accept when cmd_valid && cmd_ready on a rising edge. All registered outputs change from the next cycle.
- busy = !cmd_ready.
- States:
  - IDLE:
    - Holds the previous pins and duty, so a motor keeps running after its command completes.
    - On accept of STOP (or op 6/7): pins = 00, duty = 0, done pulses the next cycle, stay IDLE.
    - On accept of BRAKE: pins = 11, duty = all-ones; go RUN.
    - On accept of a motion op:
      - If the new pins of either motor differ from the current pins and the current pins are not 00: go DEAD.
      - Otherwise: set the new pins, go RAMP.
  - DEAD:
    - Pins = 00, duty = 0.
    - Count DEAD_TICKS ticks, then set the new pins and go RAMP (ramp starts from duty 0).
  - RAMP:
    - On each tick, move duty toward the target by RAMP_STEP, saturating exactly at the target. No overflow or underflow: compare before add/subtract.
    - Ramp-down applies when the target is below the current duty.
    - When duty = target: go RUN with the tick counter cleared.
    - If already equal on entry: go RUN the next cycle.
  - RUN:
    - Count cmd_ticks ticks.
    - On reaching the count: done = 1 for exactly one cycle, go IDLE.
    - cmd_ticks = 0: done pulses the cycle after entering RUN.
- Ramp ticks do not count toward cmd_ticks.
- abort = 1 in any state:
  - Next cycle: pins = 00, duty = 0, state IDLE, no done pulse.
  - cmd_ready stays 0 while abort is held.
- abort and accept cannot coincide, because cmd_ready is gated by abort.
- A command held on cmd_valid while busy is not accepted until IDLE. cmd_* are captured at accept; later changes are ignored.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV = 1, RAMP_STEP = 256, DEAD_TICKS = 4, DUTY_WIDTH = 16.
- Reset, then FWD duty=1024 ticks=3:
  - Pins go 10/10; duty steps 256, 512, 768, 1024 on successive cycles.
  - 3 RUN cycles, then done pulses once; cmd_ready returns to 1; duty holds 1024.
- FWD duty=1000 from idle, then REV duty=512:
  - 4 cycles with pins 00 and duty 0, then pins 01/01 and the ramp from 0 to 512.
  - Final ramp step saturates at exactly 1000 in the first command.
- From FWD at 1024, FWD duty=300 ticks=0:
  - No dead-time; duty 768, 512, 300.
  - done pulses the cycle after RUN is entered.
- Abort mid-RAMP during TURN_L duty=4096:
  - Next cycle: pins 00/00, duty 0, motor_enable 00, no done pulse.
  - cmd_ready = 0 until abort drops.
- BRAKE ticks=2, then op 7:
  - Pins 11/11, motor_enable 11, duty 0xFFFF, done after 2 ticks.
  - op 7 then gives pins 00, duty 0, done the next cycle.
- Assert rst low mid-RUN:
  - All outputs return to reset values immediately (asynchronous), without waiting for a clock edge.
